keypad_scanner: RTL
===================

# keypad_scanner

Column-scanning reader for a 4x4 matrix keypad on a Pmod header. A rotating one-cold pattern drives the column lines, and the row lines are sampled against it. Each scan result is debounced over several complete scans, and every new debounced keypress produces a single-cycle event with its key code. It is the input-side counterpart of the display anode scan and shares the same one-cold rotation scheme.

## Interface
- NUM_COLS, 4, number of column drive lines
- NUM_ROWS, 4, number of row sense lines
- SETTLE_CYCLES, 1000, clocks each column is held low; must be >= 3
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to accept a state; must be >= 1
- CODE_W, $clog2(NUM_COLS*NUM_ROWS), key code width (derived)

- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- col_o  out  NUM_COLS  column drive, active-low one-cold
- row_i  in  NUM_ROWS  row sense, active-low (pulled up externally), asynchronous
- key_valid_o  out  1  one-cycle pulse when a new debounced key is accepted
- key_code_o  out  CODE_W  code of the last accepted key = col*NUM_ROWS + row; holds between pulses
- pressed_o  out  1  level; 1 while the debounced state is "key down"

## Operation
- row_i passes through a 2-flop synchronizer. Both stages reset to all ones.
- Column sequencer:
  - Settle counter runs 0..SETTLE_CYCLES-1.
  - At terminal count, the synchronized rows are sampled for the current column.
  - On the next edge, col_o rotates: bit i takes bit i-1, bit 0 takes bit NUM_COLS-1. Order is col 0, 1, ..., NUM_COLS-1, then wrap.
- Scan accumulator:
  - A row bit of 0 during column c is a hit.
  - The first hit in scan order is kept: lowest column wins, then lowest row within that column.
  - Later hits in the same scan are ignored.
  - The result is {found, code}, cleared at the start of each scan.
- Scan end is the sample of column NUM_COLS-1. At scan end, the result is compared to the previous scan's result:
  - Equal: stable count increments, saturating at DEBOUNCE_SCANS.
  - Different: stable count is set to 1.
- Acceptance is evaluated at scan end, using the updated stable count:
  - stable == DEBOUNCE_SCANS, found = 1, and (pressed_o == 0 or code != key_code_o): key_valid_o = 1 next cycle, key_code_o <= code, pressed_o <= 1.
  - stable == DEBOUNCE_SCANS and found = 0: pressed_o <= 0. No pulse; key_code_o is retained.
  - Otherwise there is no output change.
- A held key never repeats. A direct change from key A to key B, with no intermediate release, produces one pulse for B once B is stable.

## Timing
- Reset values:
  - col_o = all ones except bit 0 = 0.
  - key_valid_o = 0, key_code_o = 0, pressed_o = 0.
  - Settle counter, stable count, previous result and scan accumulator are all cleared.
  - Previous result resets to not-found.
- Column dwell is exactly SETTLE_CYCLES clocks. Scan period is NUM_COLS*SETTLE_CYCLES clocks.
- The sample at terminal count sees row_i as it was 2 clocks earlier. With SETTLE_CYCLES >= 3, a sample never sees a previous column's response.
- key_valid_o is high for exactly the one cycle after the final-column sample edge of the accepting scan. key_code_o and pressed_o update on the same edge that raises key_valid_o.
- Press-to-pulse latency: a press stable before scan k begins pulses at the end of scan k+DEBOUNCE_SCANS-1.
- Reset mid-scan: on the edge where reset_i is high, all state returns to reset values.
  - col_o = ...1110 the following cycle.
  - A pending acceptance is discarded.
  - key_valid_o is not asserted.

## Test plan
Bench parameters: SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, 4x4 (16-cycle scan).
- Reset and idle, row_i=4'b1111:
  - col_o = 1110, 1101, 1011, 0111, each for exactly 4 cycles, then repeats.
  - key_valid_o, pressed_o and key_code_o stay 0 for 10 scans.
- Press col 2 / row 1 (row_i=1101 whenever col_o[2]=0) before scan 0 and hold for 10 scans:
  - Exactly one key_valid_o pulse, in the cycle after the final sample of scan 2, with key_code_o=9.
  - pressed_o=1 from that cycle onward.
- Bounce the same key present/absent on alternating scans for 4 scans, then hold:
  - No pulse during bouncing.
  - One pulse with code 9 at the end of the 3rd stable scan.
- Simultaneous col 1 / row 3 and col 3 / row 0:
  - One pulse with code 7.
  - Then release col 1 / row 3 while keeping col 3 / row 0: after 3 scans, one pulse with code 12, and pressed_o stays 1 throughout.
- Release all keys:
  - pressed_o falls at the end of the 3rd empty scan, with no pulse; key_code_o holds 12.
  - Then press col 0 / row 0: pulse with code 0.
- Assert reset_i for 1 cycle mid-column during the 2nd debounce scan of a press:
  - col_o = 1110 the next cycle, no pulse emitted.
  - Pulse arrives only after 3 full scans following reset.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning reader for a 4x4 matrix keypad.
// Drives a rotating one-cold column pattern and samples the rows late in each column.
// Whole-scan results are debounced, and each new accepted key gives a one-cycle event.
module keypad_scanner #(
   parameter int NUM_COLS       = 4,
   parameter int NUM_ROWS       = 4,
   parameter int SETTLE_CYCLES  = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int CODE_W         = $clog2(NUM_COLS*NUM_ROWS)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   output logic [NUM_COLS-1:0] col_o,
   input  logic [NUM_ROWS-1:0] row_i,
   output logic                key_valid_o,
   output logic [CODE_W-1:0]   key_code_o,
   output logic                pressed_o
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES);
   localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

   logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_COLS-1:0] col_q, col_d;
   logic [COL_W-1:0]    col_idx_q, col_idx_d;
   logic                acc_found_q, acc_found_d;
   logic [CODE_W-1:0]   acc_code_q, acc_code_d;
   logic                prev_found_q, prev_found_d;
   logic [CODE_W-1:0]   prev_code_q, prev_code_d;
   logic [STB_W-1:0]    stable_q, stable_d;
   logic                valid_q, valid_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                pressed_q, pressed_d;

   logic                row_hit;
   logic [ROW_W-1:0]    row_sel;
   logic [CODE_W-1:0]   hit_code;
   logic                scan_found;
   logic [CODE_W-1:0]   scan_code;
   logic [STB_W-1:0]    stable_n;

   // Two-flop synchronizer for the asynchronous, active-low row lines (idle = all ones).
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         row_meta_q <= '1;
         row_sync_q <= '1;
      end else begin
         row_meta_q <= row_i;
         row_sync_q <= row_meta_q;
      end
   end

   // Lowest active row in the current column and its key code.
   always_comb begin
      row_hit = 1'b0;
      row_sel = '0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (!row_sync_q[r]) begin
            row_hit = 1'b1;
            row_sel = ROW_W'(r);
         end
      end
      hit_code = CODE_W'(col_idx_q) * CODE_W'(NUM_ROWS) + CODE_W'(row_sel);
   end

   // Next state: column sequencing, scan accumulation, debounce and acceptance.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
      cnt_d        = cnt_q + CNT_W'(1);
      col_d        = col_q;
      col_idx_d    = col_idx_q;
      acc_found_d  = acc_found_q;
      acc_code_d   = acc_code_q;
      prev_found_d = prev_found_q;
      prev_code_d  = prev_code_q;
      stable_d     = stable_q;
      valid_d      = 1'b0;
      code_d       = code_q;
      pressed_d    = pressed_q;
      scan_found   = acc_found_q;
      scan_code    = acc_code_q;
      stable_n     = stable_q;

      if (cnt_q == CNT_LAST) begin
         cnt_d     = '0;
         col_d     = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
         col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + COL_W'(1);

         // The first hit in scan order wins; later hits are ignored.
         if (!acc_found_q && row_hit) begin
            scan_found = 1'b1;
            scan_code  = hit_code;
         end
         acc_found_d = scan_found;
         acc_code_d  = scan_code;

         if (col_idx_q == COL_LAST) begin
            acc_found_d = 1'b0;
            acc_code_d  = '0;
            if (scan_found == prev_found_q && scan_code == prev_code_q)
               stable_n = (stable_q == STB_MAX) ? stable_q : stable_q + STB_W'(1);
            else
               stable_n = STB_W'(1);
            stable_d     = stable_n;
            prev_found_d = scan_found;
            prev_code_d  = scan_code;

            if (stable_n == STB_MAX) begin
               if (scan_found) begin
                  if (!pressed_q || scan_code != code_q) begin
                     valid_d   = 1'b1;
                     code_d    = scan_code;
                     pressed_d = 1'b1;
                  end
               end else begin
                  pressed_d = 1'b0;
               end
            end
         end
      end
   end

   // State register with synchronous reset; column 0 is driven first.
   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (reset_i) begin
         cnt_q        <= '0;
         col_q        <= {{(NUM_COLS-1){1'b1}}, 1'b0};
         col_idx_q    <= '0;
         acc_found_q  <= 1'b0;
         acc_code_q   <= '0;
         prev_found_q <= 1'b0;
         prev_code_q  <= '0;
         stable_q     <= '0;
         valid_q      <= 1'b0;
         code_q       <= '0;
         pressed_q    <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         col_q        <= col_d;
         col_idx_q    <= col_idx_d;
         acc_found_q  <= acc_found_d;
         acc_code_q   <= acc_code_d;
         prev_found_q <= prev_found_d;
         prev_code_q  <= prev_code_d;
         stable_q     <= stable_d;
         valid_q      <= valid_d;
         code_q       <= code_d;
         pressed_q    <= pressed_d;
      end
   end

   assign col_o       = col_q;
   assign key_valid_o = valid_q;
   assign key_code_o  = code_q;
   assign pressed_o   = pressed_q;

endmodule
